fade_speed_ctrl: RTL and testbench

- Upstream stage of the smooth-fade LED block.
- Turns two raw push-buttons (faster/slower) into the 16-bit speed word on that block's i_speed input.
- Each button is synchronised and debounced; presses step the speed up or down, with auto-repeat while held.
- Both buttons held together restore the default speed.

---
 rtl/fade_speed_ctrl_pkg.sv | 41 ++++
 rtl/fade_speed_ctrl_btn_debounce.sv | 56 +++++
 rtl/fade_speed_ctrl.sv | 135 +++++++++++++
 tb/tb_fade_speed_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fade_speed_ctrl_pkg.sv
// Shared constants for the smooth-fade LED path: speed word width, default
// speed limits, speed-control FSM encodings and the clamped step helper.
package fade_speed_ctrl_pkg;

    localparam int unsigned FADE_SPEED_W   = 16;
    localparam int unsigned SPEED_INIT_DEF = 200;
    localparam int unsigned SPEED_MIN_DEF  = 16;
    localparam int unsigned SPEED_MAX_DEF  = 4096;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HOLD_UP   = 2'd1;
    localparam logic [1:0] ST_HOLD_DN   = 2'd2;
    localparam logic [1:0] ST_HOLD_BOTH = 2'd3;

    // One speed step in 17-bit arithmetic, clamped to [min, max]; a borrow
    // out of the subtraction means the result went below zero.
    function automatic logic [FADE_SPEED_W-1:0] step_speed(
        input logic [FADE_SPEED_W-1:0] cur,
        input logic                    dir_up,
        input logic [FADE_SPEED_W-1:0] step,
        input logic [FADE_SPEED_W-1:0] min_v,
        input logic [FADE_SPEED_W-1:0] max_v
    );
        logic [FADE_SPEED_W:0] w_sum;
        if (dir_up) begin
            w_sum = {1'b0, cur} + {1'b0, step};
        end else begin
            w_sum = {1'b0, cur} - {1'b0, step};
        end
        if (!dir_up && w_sum[FADE_SPEED_W]) begin
            return min_v;
        end else if (w_sum < {1'b0, min_v}) begin
            return min_v;
        end else if (w_sum > {1'b0, max_v}) begin
            return max_v;
        end else begin
            return w_sum[FADE_SPEED_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fade_speed_ctrl_btn_debounce.sv
// Button front end: polarity fix, 2-flop synchroniser and a counting
// debouncer. o_rise pulses for one cycle, aligned with o_level going high.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             w_pressed;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    assign w_pressed = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;

    // Two-stage synchroniser; reset loads the released (not pressed) level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], w_pressed};
        end
    end

    // Count consecutive samples that disagree with the accepted level and
    // flip the level once DEBOUNCE_CYCLES of them have been seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt  <= '0;
            r_rise <= 1'b0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
            r_rise  <= ~r_level;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_rise <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/fade_speed_ctrl.sv
// Speed control for the smooth-fade LED block: two debounced buttons step a
// 16-bit speed word up/down with auto-repeat; both held restores the default.
module fade_speed_ctrl
    import fade_speed_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_RATE     = 1200000,
    parameter int unsigned SPEED_INIT      = SPEED_INIT_DEF,
    parameter int unsigned SPEED_MIN       = SPEED_MIN_DEF,
    parameter int unsigned SPEED_MAX       = SPEED_MAX_DEF,
    parameter int unsigned STEP            = 16,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_btn_up,
    input  logic                    i_btn_dn,
    output logic [FADE_SPEED_W-1:0] o_speed,
    output logic                    o_speed_upd,
    output logic [1:0]              o_btn_state
);

    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [FADE_SPEED_W-1:0] P_INIT = FADE_SPEED_W'(SPEED_INIT);
    localparam logic [FADE_SPEED_W-1:0] P_MIN  = FADE_SPEED_W'(SPEED_MIN);
    localparam logic [FADE_SPEED_W-1:0] P_MAX  = FADE_SPEED_W'(SPEED_MAX);
    localparam logic [FADE_SPEED_W-1:0] P_STEP = FADE_SPEED_W'(STEP);

    if (!(REPEAT_DELAY >= REPEAT_RATE && REPEAT_RATE >= 1 && DEBOUNCE_CYCLES >= 2))
    begin : g_bad_timing
        $error("fade_speed_ctrl: need REPEAT_DELAY >= REPEAT_RATE >= 1 and DEBOUNCE_CYCLES >= 2");
    end

    logic                    w_up_lvl;
    logic                    w_up_rise;
    logic                    w_dn_lvl;
    logic                    w_dn_rise;
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [REP_W-1:0]        r_rep;
    logic [REP_W-1:0]        w_rep_nxt;
    logic [FADE_SPEED_W-1:0] r_speed;
    logic [FADE_SPEED_W-1:0] w_speed_nxt;
    logic                    r_upd;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (BTN_ACTIVE_LOW)
    ) u_btn_up (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (i_btn_up),
        .o_level(w_up_lvl),
        .o_rise (w_up_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (BTN_ACTIVE_LOW)
    ) u_btn_dn (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (i_btn_dn),
        .o_level(w_dn_lvl),
        .o_rise (w_dn_rise)
    );

    // Next state, repeat timer and speed; the both-held check overrides
    // every state so a same-cycle double press goes straight to restore.
    always_comb begin
        w_state_nxt = r_state;
        w_rep_nxt   = r_rep;
        w_speed_nxt = r_speed;
        if (w_up_lvl && w_dn_lvl) begin
            w_state_nxt = ST_HOLD_BOTH;
            if (r_state != ST_HOLD_BOTH) begin
                w_speed_nxt = P_INIT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_up_rise) begin
                        w_state_nxt = ST_HOLD_UP;
                        w_rep_nxt   = REP_W'(REPEAT_DELAY);
                        w_speed_nxt = step_speed(r_speed, 1'b1, P_STEP, P_MIN, P_MAX);
                    end else if (w_dn_rise) begin
                        w_state_nxt = ST_HOLD_DN;
                        w_rep_nxt   = REP_W'(REPEAT_DELAY);
                        w_speed_nxt = step_speed(r_speed, 1'b0, P_STEP, P_MIN, P_MAX);
                    end
                end
                ST_HOLD_UP, ST_HOLD_DN: begin
                    if ((r_state == ST_HOLD_UP) ? !w_up_lvl : !w_dn_lvl) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_rep == REP_W'(1)) begin
                        // Timer reaches zero on this edge: step and reload.
                        w_rep_nxt   = REP_W'(REPEAT_RATE);
                        w_speed_nxt = step_speed(r_speed, r_state == ST_HOLD_UP,
                                                 P_STEP, P_MIN, P_MAX);
                    end else begin
                        w_rep_nxt = r_rep - 1'b1;
                    end
                end
                ST_HOLD_BOTH: begin
                    if (!w_up_lvl && !w_dn_lvl) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Register FSM, timer and speed; the update flag marks real value changes only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rep   <= '0;
            r_speed <= P_INIT;
            r_upd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rep   <= w_rep_nxt;
            r_speed <= w_speed_nxt;
            r_upd   <= (w_speed_nxt != r_speed);
        end
    end

    assign o_speed     = r_speed;
    assign o_speed_upd = r_upd;
    assign o_btn_state = {w_dn_lvl, w_up_lvl};

endmodule

// File: tb/tb_fade_speed_ctrl.sv
// Directed bench for fade_speed_ctrl with a scoreboard of expected speed
// updates (value and edge number) checked whenever o_speed_upd pulses.
module tb_fade_speed_ctrl;

    localparam int DEB   = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 8;
    localparam int STEPV = 16;
    localparam int SMIN  = 16;
    localparam int SMAX  = 256;
    localparam int SINIT = 200;

    typedef struct {
        int speed;
        int cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        btn_up;
    logic        btn_dn;
    logic [15:0] o_speed;
    logic        o_speed_upd;
    logic [1:0]  o_btn_state;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   model   = SINIT;
    logic [15:0] prev_speed;

    fade_speed_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE),
        .SPEED_INIT     (SINIT),
        .SPEED_MIN      (SMIN),
        .SPEED_MAX      (SMAX),
        .STEP           (STEPV),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn_up   (btn_up),
        .i_btn_dn   (btn_dn),
        .o_speed    (o_speed),
        .o_speed_upd(o_speed_upd),
        .o_btn_state(o_btn_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < SMIN) return SMIN;
        if (v > SMAX) return SMAX;
        return v;
    endfunction

    // Monitor: every update pulse must match the oldest expectation; between
    // pulses the speed must not move.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (rst_n) begin
            if (o_speed_upd) begin
                chk("upd_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("upd_value", o_speed, e.speed);
                    chk("upd_cycle", cyc, e.cyc);
                end
            end else begin
                chk("speed_stable", o_speed, prev_speed);
            end
        end
        prev_speed = o_speed;
    end

    // Press the selected buttons for n edges; for a single button, predict
    // each step edge. The sampling edge s is the first of DEB+3 latency edges;
    // the level falls at s+n+DEB+1 so later steps are dropped.
    task automatic hold(input bit up, input bit dn, input int n);
        int s;
        int t;
        int sp;
        int nv;
        bit first;
        @(negedge clk);
        btn_up = up ? 1'b0 : 1'b1;
        btn_dn = dn ? 1'b0 : 1'b1;
        s = cyc + 1;
        if ((up ^ dn) && n >= DEB) begin
            sp    = model;
            t     = s + DEB + 2;
            first = 1'b1;
            while (t <= s + n + DEB + 1) begin
                nv = clampv(sp + (up ? STEPV : -STEPV));
                if (nv != sp) sb.push_back('{nv, t});
                sp = nv;
                t  = first ? t + DELAY : t + RATE;
                first = 1'b0;
            end
            model = sp;
        end
        repeat (n) @(negedge clk);
        btn_up = 1'b1;
        btn_dn = 1'b1;
    endtask

    // Asynchronous reset between clock edges; output must return at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_speed", o_speed, SINIT);
        chk("rst_async_upd", o_speed_upd, 0);
        chk("rst_async_btn", o_btn_state, 0);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model = SINIT;
    endtask

    initial begin
        int s;
        rst_n  = 1'b0;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        prev_speed = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_speed", o_speed, SINIT);
        chk("reset_upd", o_speed_upd, 0);
        chk("reset_btn", o_btn_state, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Short glitch is filtered.
        hold(1, 0, 3);
        repeat (20) @(negedge clk);
        chk("glitch_speed", o_speed, SINIT);
        chk("glitch_btn", o_btn_state, 0);
        chk("glitch_sb", sb.size(), 0);

        // Single press.
        hold(1, 0, 10);
        repeat (15) @(negedge clk);
        chk("press_up_speed", o_speed, 216);
        chk("press_up_sb", sb.size(), 0);

        // Reset in the middle of a repeat wait aborts further steps.
        @(negedge clk);
        btn_up = 1'b0;
        s = cyc + 1;
        sb.push_back('{232, s + DEB + 2});
        repeat (15) @(negedge clk);
        chk("abort_btn_held", o_btn_state, 2'b01);
        do_reset();
        repeat (40) @(negedge clk);
        chk("abort_speed", o_speed, SINIT);
        chk("abort_sb", sb.size(), 0);

        // Down with auto-repeat: 184,168,152,136,120,104.
        hold(0, 1, 60);
        repeat (20) @(negedge clk);
        chk("repeat_dn_speed", o_speed, 104);
        chk("repeat_dn_sb", sb.size(), 0);

        // Up to the upper bound, then repeats without pulses.
        hold(1, 0, 125);
        repeat (20) @(negedge clk);
        chk("sat_max_speed", o_speed, SMAX);
        chk("sat_max_sb", sb.size(), 0);

        // Down to the lower bound.
        hold(0, 1, 170);
        repeat (20) @(negedge clk);
        chk("sat_min_speed", o_speed, SMIN);
        chk("sat_min_sb", sb.size(), 0);

        // Get to 120, then press both on the same edge.
        do_reset();
        repeat (5) @(negedge clk);
        hold(0, 1, 46);
        repeat (20) @(negedge clk);
        chk("pre_both_speed", o_speed, 120);
        @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        s = cyc + 1;
        sb.push_back('{SINIT, s + DEB + 2});
        model = SINIT;
        repeat (50) @(negedge clk);
        chk("both_btn", o_btn_state, 2'b11);
        chk("both_speed", o_speed, SINIT);
        chk("both_sb", sb.size(), 0);
        btn_dn = 1'b1;
        repeat (30) @(negedge clk);
        chk("both_rel_dn_btn", o_btn_state, 2'b01);
        chk("both_rel_dn_speed", o_speed, SINIT);
        btn_up = 1'b1;
        repeat (20) @(negedge clk);
        chk("both_rel_all_btn", o_btn_state, 0);

        // Back in IDLE: a fresh press steps normally.
        hold(1, 0, 10);
        repeat (20) @(negedge clk);
        chk("post_both_speed", o_speed, 216);
        chk("final_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
